// File: rtl/sector_cache_model_if.sv
// sector_cache_model_if
// Address/response handshake bundle for sector_cache_model.
//   addr_valid_41 / addr_41 / addr_ready_41 : valid/ready address port
//   flush_41                                : one-cycle invalidate-all request
//   resp_valid_41 / resp_hit_41             : per-access hit/miss strobe
// Modports: master drives addresses (bench side), slave is the cache model.
interface sector_cache_model_if #(
  parameter int ADDR_W = 31
);
  logic              addr_valid_41;
  logic [ADDR_W-1:0] addr_41;
  logic              addr_ready_41;
  logic              flush_41;
  logic              resp_valid_41;
  logic              resp_hit_41;

  modport master (
    output addr_valid_41, addr_41, flush_41,
    input  addr_ready_41, resp_valid_41, resp_hit_41
  );

  modport slave (
    input  addr_valid_41, addr_41, flush_41,
    output addr_ready_41, resp_valid_41, resp_hit_41
  );
endinterface

// File: rtl/sector_cache_model.sv
// sector_cache_model
// Set-associative sector-cache hit/miss model with true-LRU replacement.
// Only tags, valid bits, sector-valid bits and LRU ages are kept; no data.
// Ports:
//   clk_41           : clock, all state changes on the rising edge
//   rst_41           : asynchronous active-low reset
//   bus (slave)      : address handshake, flush request, response strobe
//   hits_41          : saturating hit counter
//   misses_41        : saturating miss counter (tag and sector misses)
//   sector_misses_41 : saturating sector-miss counter, present only when
//                      the macro SECTOR_MISS_CNT_EN is defined
// After reset (and after every flush) the tag store is swept one set per
// cycle; addr_ready_41 stays low for SETS cycles during each sweep.
module sector_cache_model #(
  parameter int ADDR_W     = 31,
  parameter int LINE_BYTES = 64,
  parameter int SECTORS    = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int CNT_W      = 31
) (
  input  logic               clk_41,
  input  logic               rst_41,
  sector_cache_model_if.slave bus,
`ifdef SECTOR_MISS_CNT_EN
  output logic [CNT_W-1:0]   sector_misses_41,
`endif
  output logic [CNT_W-1:0]   hits_41,
  output logic [CNT_W-1:0]   misses_41
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int SEC_W  = $clog2(SECTORS);
  localparam int SEC_IW = (SEC_W > 0) ? SEC_W : 1;
  localparam int SET_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - SET_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_t;

  state_t           state_reg;
  logic [SET_W-1:0] sweep_set_reg;
  logic             ready_reg;
  logic             stage_valid_reg, stage_hit_reg;
  logic             resp_valid_reg, resp_hit_reg;
  logic [CNT_W-1:0] hits_reg, misses_reg;

  // Address decode
  logic [SET_W-1:0]   set_idx;
  logic [TAG_W-1:0]   tag_in;
  logic [SEC_IW-1:0]  sec_idx;
  logic [SECTORS-1:0] sec_bit;
  logic               accept;
  logic               addr_unused;

  assign set_idx = bus.addr_41[OFF_W +: SET_W];
  assign tag_in  = bus.addr_41[ADDR_W-1 -: TAG_W];
  assign accept  = (state_reg == ST_IDLE) && bus.addr_valid_41;
  // Byte-within-sector bits never matter; fold the whole bus here.
  assign addr_unused = ^bus.addr_41;

  generate
    if (SEC_W > 0) begin : g_sec
      assign sec_idx = bus.addr_41[OFF_W-1 -: SEC_IW];
    end else begin : g_nosec
      assign sec_idx = '0;
    end
  endgenerate

  assign sec_bit = SECTORS'(1) << sec_idx;

  // Per-way view of the addressed set
  logic               way_valid [WAYS];
  logic [TAG_W-1:0]   way_tag   [WAYS];
  logic [SECTORS-1:0] way_sect  [WAYS];
  logic [WAY_W-1:0]   way_age   [WAYS];

  logic             any_match, any_invalid, sect_set, hit, sector_miss;
  logic [WAY_W-1:0] match_way, victim_way, touched_way, old_age;

  always_comb begin
    any_match   = 1'b0;
    any_invalid = 1'b0;
    match_way   = '0;
    victim_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == tag_in)) begin
        any_match = 1'b1;
        match_way = WAY_W'(w);
      end
    end
    // Scanning high to low leaves the lowest-index invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        any_invalid = 1'b1;
        victim_way  = WAY_W'(w);
      end
    end
    if (!any_invalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (way_age[w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
    end
    touched_way = any_match ? match_way : victim_way;
    old_age     = way_age[touched_way];
    sect_set    = |(way_sect[match_way] & sec_bit);
    hit         = any_match && sect_set;
    sector_miss = any_match && !sect_set;
  end

  // Tag store, one set of arrays per way. Reads are combinational so that
  // back-to-back accesses to one set see the previous update without a stall.
  // No reset here: the INIT sweep establishes the contents.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic               valid_mem [SETS];
      logic [TAG_W-1:0]   tag_mem   [SETS];
      logic [SECTORS-1:0] sect_mem  [SETS];
      logic [WAY_W-1:0]   age_mem   [SETS];
      logic               is_touched;

      assign is_touched = (touched_way == WAY_W'(gi));

      always_ff @(posedge clk_41) begin
        if (state_reg != ST_IDLE) begin
          valid_mem[sweep_set_reg] <= 1'b0;
          sect_mem[sweep_set_reg]  <= '0;
          age_mem[sweep_set_reg]   <= WAY_W'(gi);
        end else if (accept) begin
          if (is_touched) begin
            valid_mem[set_idx] <= 1'b1;
            tag_mem[set_idx]   <= tag_in;
            // A tag miss drops every previously valid sector of the victim.
            sect_mem[set_idx]  <= (any_match ? way_sect[gi] : '0) | sec_bit;
            age_mem[set_idx]   <= '0;
          end else if (way_age[gi] < old_age) begin
            age_mem[set_idx]   <= way_age[gi] + 1'b1;
          end
        end
      end

      assign way_valid[gi] = valid_mem[set_idx];
      assign way_tag[gi]   = tag_mem[set_idx];
      assign way_sect[gi]  = sect_mem[set_idx];
      assign way_age[gi]   = age_mem[set_idx];
    end
  endgenerate

`ifdef SECTOR_MISS_CNT_EN
  logic [CNT_W-1:0] sector_misses_reg;
  assign sector_misses_41 = sector_misses_reg;
`endif

  // Control FSM, response pipeline and counters
  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) begin
      state_reg         <= ST_INIT;
      sweep_set_reg     <= '0;
      ready_reg         <= 1'b0;
      stage_valid_reg   <= 1'b0;
      stage_hit_reg     <= 1'b0;
      resp_valid_reg    <= 1'b0;
      resp_hit_reg      <= 1'b0;
      hits_reg          <= '0;
      misses_reg        <= '0;
`ifdef SECTOR_MISS_CNT_EN
      sector_misses_reg <= '0;
`endif
    end else begin
      // Result is captured on the accepting edge and presented one edge later.
      stage_valid_reg <= accept;
      stage_hit_reg   <= accept && hit;
      resp_valid_reg  <= stage_valid_reg;
      resp_hit_reg    <= stage_hit_reg;

      if (accept) begin
        if (hit) begin
          if (hits_reg != '1) hits_reg <= hits_reg + 1'b1;
        end else begin
          if (misses_reg != '1) misses_reg <= misses_reg + 1'b1;
        end
`ifdef SECTOR_MISS_CNT_EN
        if (sector_miss && (sector_misses_reg != '1))
          sector_misses_reg <= sector_misses_reg + 1'b1;
`endif
      end

      case (state_reg)
        ST_INIT, ST_FLUSH: begin
          sweep_set_reg <= sweep_set_reg + 1'b1;
          if (sweep_set_reg == '1) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          // An access offered alongside the flush is committed first (above).
          if (bus.flush_41) begin
            state_reg     <= ST_FLUSH;
            sweep_set_reg <= '0;
            ready_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_INIT;
          sweep_set_reg <= '0;
          ready_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr_ready_41 = ready_reg;
  assign bus.resp_valid_41 = resp_valid_reg;
  assign bus.resp_hit_41   = resp_hit_reg;
  assign hits_41           = hits_reg;
  assign misses_41         = misses_reg;

endmodule

// File: tb/tb_sector_cache_model.sv
// tb_sector_cache_model
// Directed bench for sector_cache_model: reset/init sweep, sector hits and
// misses, LRU eviction, flush, flush coinciding with an access, counter
// saturation (second instance with CNT_W = 3) and asynchronous reset.
// Builds with or without SECTOR_MISS_CNT_EN.
module tb_sector_cache_model;

  logic clk_41 = 1'b0;
  logic rst_41 = 1'b0;
  always #5 clk_41 = ~clk_41;

  sector_cache_model_if #(.ADDR_W(31)) bus ();
  sector_cache_model_if #(.ADDR_W(31)) bus_s ();

  logic [30:0] hits_41, misses_41;
  logic [2:0]  hits_s, misses_s;
`ifdef SECTOR_MISS_CNT_EN
  logic [30:0] sector_misses_41;
  logic [2:0]  sector_misses_s;
`endif

  sector_cache_model u_dut (
    .clk_41           (clk_41),
    .rst_41           (rst_41),
    .bus              (bus),
`ifdef SECTOR_MISS_CNT_EN
    .sector_misses_41 (sector_misses_41),
`endif
    .hits_41          (hits_41),
    .misses_41        (misses_41)
  );

  sector_cache_model #(.CNT_W(3)) u_sat (
    .clk_41           (clk_41),
    .rst_41           (rst_41),
    .bus              (bus_s),
`ifdef SECTOR_MISS_CNT_EN
    .sector_misses_41 (sector_misses_s),
`endif
    .hits_41          (hits_s),
    .misses_41        (misses_s)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access: offer at a negedge, accepted on the next posedge, response
  // visible after the following posedge.
  task automatic access(input bit sat, input logic [30:0] addr, input logic exp_hit,
                        input string tag);
    @(negedge clk_41);
    check({tag, "_ready"}, sat ? bus_s.addr_ready_41 : bus.addr_ready_41, 1'b1);
    if (sat) begin
      bus_s.addr_valid_41 = 1'b1;
      bus_s.addr_41       = addr;
    end else begin
      bus.addr_valid_41 = 1'b1;
      bus.addr_41       = addr;
    end
    @(negedge clk_41);
    bus.addr_valid_41   = 1'b0;
    bus_s.addr_valid_41 = 1'b0;
    check({tag, "_rv_early"}, sat ? bus_s.resp_valid_41 : bus.resp_valid_41, 1'b0);
    @(negedge clk_41);
    check({tag, "_rv"}, sat ? bus_s.resp_valid_41 : bus.resp_valid_41, 1'b1);
    check({tag, "_hit"}, sat ? bus_s.resp_hit_41 : bus.resp_hit_41, exp_hit);
    $display("[TB] %s addr=%0d resp_hit=%0b expect=%0b", tag, addr,
             sat ? bus_s.resp_hit_41 : bus.resp_hit_41, exp_hit);
  endtask

  // Counts negedges with addr_ready_41 low (starting at n0), bounded.
  task automatic wait_ready(input int n0, input string tag);
    int n;
    n = n0;
    while (!bus.addr_ready_41 && n < 1000) begin
      n++;
      @(negedge clk_41);
    end
    check({tag, "_ready_low_cycles"}, n, 64);
  endtask

  task automatic check_cnt(input string tag, input int h, input int m);
    check({tag, "_hits"}, hits_41, h);
    check({tag, "_misses"}, misses_41, m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr_valid_41   = 1'b0;
    bus.addr_41         = '0;
    bus.flush_41        = 1'b0;
    bus_s.addr_valid_41 = 1'b0;
    bus_s.addr_41       = '0;
    bus_s.flush_41      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_41);
    check("rst_ready", bus.addr_ready_41, 1'b0);
    check("rst_rv", bus.resp_valid_41, 1'b0);
    check("rst_rh", bus.resp_hit_41, 1'b0);
    check_cnt("rst", 0, 0);
    rst_41 = 1'b1;
    wait_ready(0, "init");
    check_cnt("init", 0, 0);

    // Sector behaviour
    access(0, 31'd0,  1'b0, "sec_0");
    access(0, 31'd4,  1'b1, "sec_4");
    access(0, 31'd16, 1'b0, "sec_16");
    check_cnt("sec", 1, 2);
`ifdef SECTOR_MISS_CNT_EN
    check("sec_smiss", sector_misses_41, 1);
`endif

    // Flush
    access(0, 31'd4096, 1'b0, "fl_4096");
    @(negedge clk_41);
    bus.flush_41 = 1'b1;
    @(negedge clk_41);
    bus.flush_41 = 1'b0;
    wait_ready(0, "flush");
    check_cnt("flush", 1, 3);
    access(0, 31'd0, 1'b0, "fl_0");

    // LRU eviction (set 0)
    access(0, 31'd4096,  1'b0, "lru_4096");
    access(0, 31'd8192,  1'b0, "lru_8192");
    access(0, 31'd12288, 1'b0, "lru_12288");
    access(0, 31'd16384, 1'b0, "lru_16384");
    access(0, 31'd0,     1'b0, "lru_0");
    access(0, 31'd8192,  1'b1, "lru_8192b");
    check_cnt("lru", 2, 9);

    // Flush together with a hitting access
    @(negedge clk_41);
    bus.flush_41      = 1'b1;
    bus.addr_valid_41 = 1'b1;
    bus.addr_41       = 31'd4;
    @(negedge clk_41);
    bus.flush_41      = 1'b0;
    bus.addr_valid_41 = 1'b0;
    check("sim_ready", bus.addr_ready_41, 1'b0);
    check("sim_rv_early", bus.resp_valid_41, 1'b0);
    @(negedge clk_41);
    check("sim_rv", bus.resp_valid_41, 1'b1);
    check("sim_hit", bus.resp_hit_41, 1'b1);
    $display("[TB] sim_flush addr=4 resp_hit=%0b expect=1", bus.resp_hit_41);
    wait_ready(1, "sim");
    check_cnt("sim", 3, 9);
    access(0, 31'd4, 1'b0, "sim_4");
    check_cnt("post_sim", 3, 10);
`ifdef SECTOR_MISS_CNT_EN
    check("post_sim_smiss", sector_misses_41, 1);
`endif

    // Saturation on the CNT_W = 3 instance
    access(1, 31'd0, 1'b0, "sat_miss");
    for (int i = 0; i < 8; i++) access(1, 31'd0, 1'b1, "sat_hit");
    check("sat_hits", hits_s, 3'd7);
    check("sat_misses", misses_s, 3'd1);

    // Asynchronous reset mid-stream (a response strobe is currently high)
    access(0, 31'd4, 1'b1, "ar_4");
    bus.addr_valid_41 = 1'b1;
    bus.addr_41       = 31'd8;
    #2 rst_41 = 1'b0;
    #1;
    check("ar_ready", bus.addr_ready_41, 1'b0);
    check("ar_rv", bus.resp_valid_41, 1'b0);
    check("ar_rh", bus.resp_hit_41, 1'b0);
    check_cnt("ar", 0, 0);
    check("ar_sat_hits", hits_s, 3'd0);
    @(negedge clk_41);
    bus.addr_valid_41 = 1'b0;
    @(negedge clk_41);
    rst_41 = 1'b1;
    wait_ready(0, "ar_init");
    check_cnt("ar_init", 0, 0);
    access(0, 31'd4, 1'b0, "ar_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
